// File: rtl/adder16_cn.sv
// 16-bit carry-lookahead adder: four 4-bit lookahead slices joined by a group-lookahead
// unit, with the sum and carry-out registered once for use as a pipeline stage.

module adder4_cn (
   input  logic [3:0] a,
   input  logic [3:0] b,
   input  logic       cin,
   output logic [3:0] s,
   output logic       cout,
   output logic       group_g,
   output logic       group_p
);
   logic [3:0] g;
   logic [3:0] p;
   logic       c1, c2, c3, c4;

   // Every carry is a flat AND-OR of g/p and cin, so nothing ripples inside the slice.
   always_comb begin
      g  = a & b;
      p  = a ^ b;
      c1 = g[0] | (p[0] & cin);
      c2 = g[1] | (p[1] & g[0]) | (p[1] & p[0] & cin);
      c3 = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & cin);
      c4 = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0])
         | (p[3] & p[2] & p[1] & p[0] & cin);
      group_p = p[3] & p[2] & p[1] & p[0];
      group_g = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0]);
      cout    = group_g | (group_p & cin);
      s       = p ^ {c3, c2, c1, cin};
   end

   // c4 and cout are the same function; cout is the form driven out of the slice.
   logic unused_c4;
   assign unused_c4 = c4;
endmodule

module adder16_cn (
   input  logic        clk,
   input  logic        reset,
   input  logic [15:0] a,
   input  logic [15:0] b,
   input  logic        cin,
   output logic [15:0] s,
   output logic        cout
);
   logic [3:0]  grp_g;
   logic [3:0]  grp_p;
   logic [3:0]  slice_cout;
   logic [4:0]  grp_c;
   logic [15:0] s_c;
   logic        cout_c;
   logic [15:0] s_d, s_q;
   logic        cout_d, cout_q;

   for (genvar k = 0; k < 4; k++) begin : g_slice
      adder4_cn u_slice (
         .a       (a[4*k +: 4]),
         .b       (b[4*k +: 4]),
         .cin     (grp_c[k]),
         .s       (s_c[4*k +: 4]),
         .cout    (slice_cout[k]),
         .group_g (grp_g[k]),
         .group_p (grp_p[k])
      );
   end

   // Slice carry-ins come only from the group lookahead, never from a neighbour's cout.
   always_comb begin
      grp_c[0] = cin;
      grp_c[1] = grp_g[0] | (grp_p[0] & cin);
      grp_c[2] = grp_g[1] | (grp_p[1] & grp_g[0]) | (grp_p[1] & grp_p[0] & cin);
      grp_c[3] = grp_g[2] | (grp_p[2] & grp_g[1]) | (grp_p[2] & grp_p[1] & grp_g[0])
               | (grp_p[2] & grp_p[1] & grp_p[0] & cin);
      grp_c[4] = grp_g[3] | (grp_p[3] & grp_g[2]) | (grp_p[3] & grp_p[2] & grp_g[1])
               | (grp_p[3] & grp_p[2] & grp_p[1] & grp_g[0])
               | (grp_p[3] & grp_p[2] & grp_p[1] & grp_p[0] & cin);
      cout_c   = grp_c[4];
   end

   logic [3:0] unused_slice_cout;
   assign unused_slice_cout = slice_cout;

   always_comb begin
      s_d    = s_c;
      cout_d = cout_c;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         s_q    <= 16'h0000;
         cout_q <= 1'b0;
      end else begin
         s_q    <= s_d;
         cout_q <= cout_d;
      end
   end

   assign s    = s_q;
   assign cout = cout_q;
endmodule

// File: tb/tb_adder16_cn.sv
// Directed and random checks for adder16_cn, plus an exhaustive sweep of one adder4_cn slice.

module tb_adder16_cn;
   logic        clk;
   logic        reset;
   logic [15:0] a, b;
   logic        cin;
   logic [15:0] s;
   logic        cout;

   logic [3:0]  a4, b4, s4;
   logic        cin4, cout4, g4, p4;

   logic [16:0] exp_q[$];
   int          checks = 0;
   int          errors = 0;

   adder16_cn dut (
      .clk   (clk),
      .reset (reset),
      .a     (a),
      .b     (b),
      .cin   (cin),
      .s     (s),
      .cout  (cout)
   );

   adder4_cn u_slice (
      .a       (a4),
      .b       (b4),
      .cin     (cin4),
      .s       (s4),
      .cout    (cout4),
      .group_g (g4),
      .group_p (p4)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check_out(input string tag);
      logic [16:0] exp;
      checks++;
      if (exp_q.size() == 0) begin
         errors++;
         $error("FAIL %s: scoreboard empty, got cout=%b s=%h", tag, cout, s);
      end else begin
         exp = exp_q.pop_front();
         assert ({cout, s} === exp)
         else begin
            errors++;
            $error("FAIL %s: got cout=%b s=%h, expected cout=%b s=%h",
                   tag, cout, s, exp[16], exp[15:0]);
         end
      end
   endtask

   // Drive one cycle of operands, queue the expected result, check it one edge later.
   task automatic step(input logic [15:0] ta, input logic [15:0] tb, input logic tc,
                       input logic tr, input logic [16:0] texp, input string tag);
      @(negedge clk);
      a = ta; b = tb; cin = tc; reset = tr;
      exp_q.push_back(texp);
      @(posedge clk);
      #1;
      check_out(tag);
   endtask

   initial begin
      logic [16:0] model;
      logic [15:0] ra, rb;
      logic        rc, rr;
      logic [8:0]  vec;

      reset = 1'b1; a = '0; b = '0; cin = 1'b0;
      a4 = '0; b4 = '0; cin4 = 1'b0;

      for (int i = 0; i < 512; i++) begin
         vec = 9'(i);
         {cin4, b4, a4} = vec;
         #1;
         checks++;
         assert ({cout4, s4} === ({1'b0, a4} + {1'b0, b4} + 5'(cin4)))
         else begin
            errors++;
            $error("FAIL slice4 a=%h b=%h cin=%b: got cout=%b s=%h", a4, b4, cin4, cout4, s4);
         end
      end

      step(16'hFFFF, 16'hFFFF, 1'b1, 1'b1, 17'h0_0000, "reset_hold");
      step(16'hFFFF, 16'hFFFF, 1'b1, 1'b0, 17'h1_FFFF, "reset_release");

      step(16'h0000, 16'h0000, 1'b0, 1'b0, 17'h0_0000, "c0_00");
      step(16'h0000, 16'hFFFF, 1'b0, 1'b0, 17'h0_FFFF, "c0_0f");
      step(16'hFFFF, 16'h0000, 1'b0, 1'b0, 17'h0_FFFF, "c0_f0");
      step(16'hFFFF, 16'hFFFF, 1'b0, 1'b0, 17'h1_FFFE, "c0_ff");

      step(16'h0000, 16'h0000, 1'b1, 1'b0, 17'h0_0001, "c1_00");
      step(16'h0000, 16'hFFFF, 1'b1, 1'b0, 17'h1_0000, "c1_0f");
      step(16'hFFFF, 16'h0000, 1'b1, 1'b0, 17'h1_0000, "c1_f0");
      step(16'hFFFF, 16'hFFFF, 1'b1, 1'b0, 17'h1_FFFF, "c1_ff");

      step(16'h7FFF, 16'h0001, 1'b0, 1'b0, 17'h0_8000, "b2b_first");
      step(16'h00FF, 16'h0F01, 1'b0, 1'b0, 17'h0_1000, "b2b_second");
      step(16'hA5A5, 16'h5A5A, 1'b1, 1'b0, 17'h1_0000, "all_propagate");
      step(16'h1234, 16'h4321, 1'b0, 1'b1, 17'h0_0000, "reset_midstream");
      step(16'h1234, 16'h4321, 1'b0, 1'b0, 17'h0_5555, "after_reset");

      for (int i = 0; i < 10000; i++) begin
         ra = 16'($urandom_range(0, 65535));
         rb = 16'($urandom_range(0, 65535));
         rc = 1'($urandom_range(0, 1));
         rr = ($urandom_range(0, 99) == 0);
         model = rr ? 17'h0_0000 : ({1'b0, ra} + {1'b0, rb} + 17'(rc));
         step(ra, rb, rc, rr, model, "random");
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
